// File: rtl/hilo_muldiv.sv
// hilo_muldiv: MIPS HI/LO multiply/divide unit.
// Divides always run as a 32-step restoring divider on operand magnitudes.
// Optional feature macro MULDIV_ITERATIVE_MULT_EN: when defined, multiplies
// use a 32-step shift-add; when undefined, they complete in one cycle.
`timescale 1ns/1ps

module hilo_muldiv (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic [31:0] operand_a,
    input  logic [31:0] operand_b,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int unsigned DW  = 32;
    localparam int unsigned CW  = 6;
    localparam int unsigned OPW = 3;

    localparam logic [OPW-1:0] OP_MULT  = 3'd0;
    localparam logic [OPW-1:0] OP_MULTU = 3'd1;
    localparam logic [OPW-1:0] OP_DIV   = 3'd2;
    localparam logic [OPW-1:0] OP_DIVU  = 3'd3;
    localparam logic [OPW-1:0] OP_MTHI  = 3'd4;
    localparam logic [OPW-1:0] OP_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
`ifdef MULDIV_ITERATIVE_MULT_EN
        ST_MUL  = 2'd2,
`endif
        ST_DIV  = 2'd1
    } state_t;

    state_t         state_q, state_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [DW-1:0]  rem_q, rem_d;     // divide remainder / product upper half
    logic [DW-1:0]  quo_q, quo_d;     // divide quotient / product lower half
    logic [DW-1:0]  dvs_q, dvs_d;     // divisor magnitude / multiplicand magnitude
    logic           neg_q_q, neg_q_d; // negate quotient or product at the end
    logic           neg_r_q, neg_r_d; // negate remainder at the end
    logic [DW-1:0]  hi_d, lo_d;

    // Operand sign handling: signed ops are MULT and DIV (op[0] clear)
    logic          op_signed;
    logic          sgn_a, sgn_b;
    logic [DW-1:0] abs_a, abs_b;
    assign op_signed = (op == OP_MULT) || (op == OP_DIV);
    assign sgn_a     = op_signed & operand_a[DW-1];
    assign sgn_b     = op_signed & operand_b[DW-1];
    assign abs_a     = sgn_a ? DW'(-operand_a) : operand_a;
    assign abs_b     = sgn_b ? DW'(-operand_b) : operand_b;

    // One restoring divide step on the {rem, quo} shift pair
    logic [DW:0]   div_sh, div_diff;
    logic          div_ge;
    logic [DW-1:0] div_rem_nxt, div_quo_nxt;
    assign div_sh      = {rem_q, quo_q[DW-1]};
    assign div_diff    = div_sh - {1'b0, dvs_q};
    assign div_ge      = ~div_diff[DW];
    assign div_rem_nxt = div_ge ? div_diff[DW-1:0] : div_sh[DW-1:0];
    assign div_quo_nxt = {quo_q[DW-2:0], div_ge};

    logic step_last;
    assign step_last = (cnt_q == CW'(DW - 1));

`ifdef MULDIV_ITERATIVE_MULT_EN
    // One shift-add multiply step: multiplier sits in quo and shifts out LSB first
    logic [DW:0]     mul_sum;
    logic [2*DW-1:0] mul_p_nxt, mul_res;
    assign mul_sum   = {1'b0, rem_q} + {1'b0, (quo_q[0] ? dvs_q : {DW{1'b0}})};
    assign mul_p_nxt = {mul_sum, quo_q[DW-1:1]};
    assign mul_res   = neg_q_q ? (2*DW)'(-mul_p_nxt) : mul_p_nxt;
`else
    // Single-cycle product; sign extension makes one multiplier serve both ops
    logic [2*DW-1:0] mul_ext_a, mul_ext_b, mul_prod;
    assign mul_ext_a = {{DW{sgn_a}}, operand_a};
    assign mul_ext_b = {{DW{sgn_b}}, operand_b};
    assign mul_prod  = mul_ext_a * mul_ext_b;
`endif

    assign busy = (state_q != ST_IDLE);

    // Next-state and datapath update
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        hi_d    = hi;
        lo_d    = lo;
        if (clk_enable) begin
            case (state_q)
                ST_IDLE: begin
                    if (op_valid) begin
                        case (op)
                            OP_MULT, OP_MULTU: begin
`ifdef MULDIV_ITERATIVE_MULT_EN
                                state_d = ST_MUL;
                                cnt_d   = '0;
                                rem_d   = '0;
                                quo_d   = abs_b;
                                dvs_d   = abs_a;
                                neg_q_d = sgn_a ^ sgn_b;
`else
                                hi_d = mul_prod[2*DW-1:DW];
                                lo_d = mul_prod[DW-1:0];
`endif
                            end
                            OP_DIV, OP_DIVU: begin
                                if (operand_b == '0) begin
                                    hi_d = operand_a;
                                    lo_d = '1;
                                end else begin
                                    state_d = ST_DIV;
                                    cnt_d   = '0;
                                    rem_d   = '0;
                                    quo_d   = abs_a;
                                    dvs_d   = abs_b;
                                    neg_q_d = sgn_a ^ sgn_b;
                                    neg_r_d = sgn_a;
                                end
                            end
                            OP_MTHI: hi_d = operand_a;
                            OP_MTLO: lo_d = operand_a;
                            default: ;
                        endcase
                    end
                end
                ST_DIV: begin
                    rem_d = div_rem_nxt;
                    quo_d = div_quo_nxt;
                    cnt_d = CW'(cnt_q + CW'(1));
                    if (step_last) begin
                        state_d = ST_IDLE;
                        lo_d    = neg_q_q ? DW'(-div_quo_nxt) : div_quo_nxt;
                        hi_d    = neg_r_q ? DW'(-div_rem_nxt) : div_rem_nxt;
                    end
                end
`ifdef MULDIV_ITERATIVE_MULT_EN
                ST_MUL: begin
                    rem_d = mul_p_nxt[2*DW-1:DW];
                    quo_d = mul_p_nxt[DW-1:0];
                    cnt_d = CW'(cnt_q + CW'(1));
                    if (step_last) begin
                        state_d = ST_IDLE;
                        hi_d    = mul_res[2*DW-1:DW];
                        lo_d    = mul_res[DW-1:0];
                    end
                end
`endif
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State and datapath registers; reset aborts any operation in flight
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            hi      <= '0;
            lo      <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            hi      <= hi_d;
            lo      <= lo_d;
        end
    end

endmodule

// File: doc/hilo_muldiv.md
# hilo_muldiv

Multiply/divide unit with the architectural HI/LO registers for the MIPS core. It sits directly downstream of `register_file`, consuming `read_data_a` (rs) and `read_data_b` (rt) for MULT/MULTU/DIV/DIVU/MTHI/MTLO. It holds the result in HI/LO for MFHI/MFLO. Divides, and optionally multiplies, are iterative, and `busy` is used to stall the pipeline.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk` in 1: clock, rising-edge.
- `reset` in 1: asynchronous, active-low; clears all state.
- `clk_enable` in 1: global stall; when low, all state, counter and HI/LO hold.
- `op_valid` in 1: request strobe for `op`.
- `op` in 3: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO; 6–7 are ignored.
- `operand_a` in 32: rs value (dividend / multiplicand / MTHI-MTLO source).
- `operand_b` in 32: rt value (divisor / multiplier).
- `busy` out 1: operation in flight; new requests are not accepted.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, MUL, DIV. `busy` = (state != IDLE), decoded from the state register only.
- Accept condition: `clk_enable && op_valid && !busy` at a rising edge. Requests while busy are dropped; the controlling stage must hold and retry.
- MTHI/MTLO: `hi`/`lo` ← `operand_a` at the accept edge; the other register is unchanged; state stays IDLE.
- DIV/DIVU:
  - Latch |a|, |b| (unsigned for DIVU) and the sign flags; state → DIV; 6-bit counter ← 0.
  - Each enabled edge runs one restoring step.
  - After step 32: LO = quotient, HI = remainder.
  - Signed fix-up: quotient negated if a[31]^b[31]; remainder takes sign of a.
  - 0x80000000 / 0xFFFFFFFF (DIV) → LO = 0x80000000, HI = 0.
- Divide by zero (`operand_b` = 0, DIV or DIVU): no iteration; HI ← `operand_a`, LO ← 0xFFFFFFFF at the accept edge; state stays IDLE.
- MULT/MULTU: {HI,LO} = full 64-bit product, signed (MULT) or unsigned (MULTU). Latency per Configuration.
- HI/LO are updated only on operation completion or MTHI/MTLO; otherwise they hold.

## Timing
- Reset values: state IDLE, `busy` = 0, `hi` = 0, `lo` = 0, counter = 0.
- Reset is honoured mid-operation: the operation is aborted and HI/LO are zeroed immediately.
- Divide timeline: accept at edge E0; `busy` is high after E0; steps occur at enabled edges E1..E32; HI/LO are written at E32 and `busy` falls after E32.
  - 32 enabled cycles of `busy`.
  - `clk_enable` low stretches the operation cycle-for-cycle.
- A new request may be accepted at the edge immediately after `busy` falls; there is no bubble.
- `hi`/`lo` are registered outputs; during an operation they hold the previous values until the completion edge.

## Configuration
- `MULDIV_ITERATIVE_MULT_EN` defined:
  - Multiplies use a 32-step shift-add in state MUL on |a|, |b|, with the signed result negated when a[31]^b[31].
  - Timing is identical to divide: `busy` for 32 enabled cycles, result at E32.
- Not defined:
  - Multiplies complete at the accept edge using a combinational 64-bit product; `busy` never asserts for MULT/MULTU.
  - State MUL is unused and is omitted from the FSM.
- Results are bit-identical in both builds; only latency differs.

## Test plan
- Reset: deassert `reset` after random ops → `hi` = `lo` = 0, `busy` = 0. Assert `reset` at step 10 of a DIV → `busy` = 0 and `hi` = `lo` = 0 without waiting for a clock.
- DIVU 100 / 7:
  - `busy` is high for exactly 32 enabled cycles; then LO = 14, HI = 2.
  - DIV 0xFFFFFF9C (−100) / 7 → LO = 0xFFFFFFF2, HI = 0xFFFFFFFE.
  - DIV 0x80000000 / 0xFFFFFFFF → LO = 0x80000000, HI = 0.
- Divide by zero: DIV 0x12345678 / 0 → HI = 0x12345678, LO = 0xFFFFFFFF on the next cycle; `busy` never high.
- Multiply:
  - MULT 0xFFFFFFFE × 3 → HI = 0xFFFFFFFF, LO = 0xFFFFFFFA.
  - MULTU 0xFFFFFFFF × 0xFFFFFFFF → HI = 0xFFFFFFFE, LO = 0x00000001.
  - Check latency: 1 cycle with the macro undefined, 32 cycles with it defined.
- Stall and contention:
  - Toggle `clk_enable` randomly during DIVU 1000 / 10 → completion is delayed by exactly the number of disabled cycles, and LO = 100.
  - Issue MTHI 0xAAAA5555 while `busy` → request ignored, HI is the divide remainder.
- Back-to-back:
  - MTLO 0x1 then MTHI 0x2 on consecutive cycles → LO = 1, HI = 2.
  - A DIVU issued on the cycle `busy` falls is accepted.
